lmmi_cfg_sequencer: RTL
=======================

// Module: lmmi_cfg_sequencer
// PURPOSE
//  Parametrised multi-channel LMMI master for LIFCL hard-IP configuration (PLL, DPHY, PCIE, ...).
//  Arbitrates per-channel register read/write commands round-robin onto N_CH hard-IP LMMI ports.
//  Shared offset/wdata bus, one-hot request. Timeout per transaction; one response stream.
//  Sits between fabric config logic and the hard-IP primitive instances in fuzzer/test designs.
// PARAMETERS
//  N_CH      2    number of hard-IP LMMI channels (1..8)
//  OFFSET_W  7    LMMI register offset width
//  DATA_W    8    LMMI data width
//  TIMEOUT   255  max wait cycles for lmmi_ready / lmmi_rdata_valid; 0 disables timeout
// PORTS
//  clk               in   1            single clock; all logic rising-edge
//  rst_n             in   1            async active-low reset
//  cmd_valid         in   N_CH         per-channel command valid
//  cmd_ready         out  N_CH         one-hot pulse: command accepted this cycle
//  cmd_wr            in   N_CH         1=write, 0=read
//  cmd_offset        in   N_CH*OFFSET_W packed per-channel offsets
//  cmd_wdata         in   N_CH*DATA_W  packed per-channel write data
//  rsp_valid         out  1            response valid, held until rsp_ready
//  rsp_ready         in   1            response consumer ready
//  rsp_ch            out  CH_W         channel of response (CH_W=max(1,$clog2(N_CH)))
//  rsp_rdata         out  DATA_W       read data (0 for writes and errors)
//  rsp_err           out  1            1 = timed out
//  lmmi_request      out  N_CH         one-hot request to hard IP
//  lmmi_wr_rdn       out  1            shared: 1=write
//  lmmi_offset       out  OFFSET_W     shared offset
//  lmmi_wdata        out  DATA_W       shared write data
//  lmmi_ready        in   N_CH         per-IP ready
//  lmmi_rdata        in   N_CH*DATA_W  per-IP read data
//  lmmi_rdata_valid  in   N_CH         per-IP read data valid
// BEHAVIOUR
//  - Reset (async, any state): all outputs 0, state IDLE, rr pointer 0, timeout counter 0.
//  - FSM IDLE->REQ->(WAIT_RD)->RESP->IDLE; one transaction in flight.
//  - IDLE: if any cmd_valid, grant first valid channel at/after rr pointer; cmd_ready[g]=1 that cycle;
//    latch wr/offset/wdata/ch; rr pointer <= g+1 mod N_CH. Next state REQ. Latency grant->request = 1.
//  - REQ: lmmi_request[g]=1, bus stable. On lmmi_ready[g]: write -> RESP (rdata 0, err 0);
//    read with lmmi_rdata_valid[g] same cycle -> capture data, RESP; read otherwise -> WAIT_RD.
//  - WAIT_RD: request 0, bus held; on lmmi_rdata_valid[g] capture lmmi_rdata[g] -> RESP.
//  - RESP: rsp_valid=1, fields stable until rsp_ready; handshake -> IDLE. No grant in same cycle,
//    so back-to-back commands are spaced by >=1 IDLE cycle.
//  - Timeout: counter clears on entry to REQ and to WAIT_RD, increments each cycle there;
//    when counter==TIMEOUT with no completion -> RESP with rsp_err=1, rsp_rdata=0, request dropped.
//    TIMEOUT=0: wait forever.
//  - ready/rdata_valid from non-granted channels ignored; rdata_valid in REQ for a write ignored.
//  - cmd_* of non-granted channels may change freely; requester holds until its cmd_ready pulse.
//  - Reset mid-transaction: lmmi_request drops immediately (async); no response emitted.
// STRUCTURE
//  - lmmi_seq_pkg: state encodings (IDLE/REQ/WAIT_RD/RESP), CH_W/TO_W width helper functions.
//  - Sub-module lmmi_rr_arbiter (N_CH param): req vector + pointer -> one-hot grant + index.
//  - Top holds FSM, latched command, timeout counter, response registers.
// TESTING
//  1 Write ch0 off=0x12 data=0xA5, ready at first REQ cycle -> request[0] 1 cycle, rsp ch0 err0 rdata0.
//  2 Read ch1 off=0x40, ready after 3 cycles, rdata_valid=0x3C 2 cycles later -> rsp ch1 rdata 0x3C.
//  3 N_CH=4 all cmd_valid held -> grants 0,1,2,3,0 in order; exactly one cmd_ready per grant.
//  4 TIMEOUT=8, lmmi_ready never -> rsp_err=1 8 cycles after request, rdata 0, request low.
//  5 rsp_ready low 5 cycles -> rsp fields stable, no new cmd_ready, lmmi_request all 0.
//  6 rst_n low during WAIT_RD -> all outputs 0 asynchronously; after release new cmd grants ch0.

Source files
------------

// File: rtl/lmmi_seq_pkg.sv
// Shared types and width helpers for the LMMI configuration sequencer.
package lmmi_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_WAIT_RD = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   // Channel index width; a single channel still needs one bit.
   function automatic int unsigned ch_w(input int unsigned n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

   // Timeout counter width, able to hold the value TIMEOUT itself.
   function automatic int unsigned to_w(input int unsigned timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/lmmi_rr_arbiter.sv
// Round-robin picker: first requesting channel at or after the pointer.
module lmmi_rr_arbiter
   import lmmi_seq_pkg::*;
#(
   parameter int unsigned N_CH = 2,
   localparam int unsigned CH_W = ch_w(N_CH)
) (
   input  logic [N_CH-1:0] req_i,
   input  logic [CH_W-1:0] ptr_i,
   output logic [N_CH-1:0] gnt_c_o,
   output logic [CH_W-1:0] idx_c_o,
   output logic            vld_c_o
);

   logic [2*N_CH-1:0] dbl;
   logic [N_CH-1:0]   rot;
   int unsigned       sel;

   // Rotate so bit 0 is the pointer channel, then take the lowest set bit.
   always_comb begin
      dbl     = {req_i, req_i} >> ptr_i;
      rot     = dbl[N_CH-1:0];
      sel     = 0;
      vld_c_o = 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (!vld_c_o && rot[i]) begin
            sel     = i;
            vld_c_o = 1'b1;
         end
      end
      idx_c_o = CH_W'((32'(ptr_i) + sel) % N_CH);
      gnt_c_o = vld_c_o ? (N_CH'(1) << idx_c_o) : '0;
   end

endmodule

// File: rtl/lmmi_cfg_sequencer.sv
// Multi-channel LMMI master: round-robin command arbitration, one transaction
// in flight, per-transaction timeout and a single response stream.
module lmmi_cfg_sequencer
   import lmmi_seq_pkg::*;
#(
   parameter int unsigned N_CH     = 2,
   parameter int unsigned OFFSET_W = 7,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned TIMEOUT  = 255,
   localparam int unsigned CH_W    = ch_w(N_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH-1:0]          cmd_valid,
   output logic [N_CH-1:0]          cmd_ready,
   input  logic [N_CH-1:0]          cmd_wr,
   input  logic [N_CH*OFFSET_W-1:0] cmd_offset,
   input  logic [N_CH*DATA_W-1:0]   cmd_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [CH_W-1:0]          rsp_ch,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err,
   output logic [N_CH-1:0]          lmmi_request,
   output logic                     lmmi_wr_rdn,
   output logic [OFFSET_W-1:0]      lmmi_offset,
   output logic [DATA_W-1:0]        lmmi_wdata,
   input  logic [N_CH-1:0]          lmmi_ready,
   input  logic [N_CH*DATA_W-1:0]   lmmi_rdata,
   input  logic [N_CH-1:0]          lmmi_rdata_valid
);

   localparam int unsigned TO_W = to_w(TIMEOUT);

   state_e              state_q, state_d;
   logic [CH_W-1:0]     rr_q, rr_d, ch_q, ch_d;
   logic [N_CH-1:0]     gsel_q, gsel_d, req_q, req_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic                wr_q, wr_d;
   logic [OFFSET_W-1:0] off_q, off_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

   logic [N_CH-1:0]     gnt_c;
   logic [CH_W-1:0]     gidx_c;
   logic                gvld_c;
   logic                wr_sel, sel_rdy, sel_rvld, to_hit;
   logic [OFFSET_W-1:0] off_sel;
   logic [DATA_W-1:0]   wdata_sel, rdata_sel;

   lmmi_rr_arbiter #(.N_CH(N_CH)) u_arb (
      .req_i   (cmd_valid),
      .ptr_i   (rr_q),
      .gnt_c_o (gnt_c),
      .idx_c_o (gidx_c),
      .vld_c_o (gvld_c)
   );

   // Command mux by fresh grant; response mux by latched grant.
   always_comb begin
      wr_sel    = |(cmd_wr & gnt_c);
      sel_rdy   = |(lmmi_ready & gsel_q);
      sel_rvld  = |(lmmi_rdata_valid & gsel_q);
      off_sel   = '0;
      wdata_sel = '0;
      rdata_sel = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (gnt_c[i]) begin
            off_sel   = cmd_offset[i*OFFSET_W +: OFFSET_W];
            wdata_sel = cmd_wdata[i*DATA_W +: DATA_W];
         end
         if (gsel_q[i]) rdata_sel = lmmi_rdata[i*DATA_W +: DATA_W];
      end
   end

   assign to_hit = (TIMEOUT != 0) && (to_cnt_q == TO_W'(TIMEOUT));

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      ch_d        = ch_q;
      gsel_d      = gsel_q;
      req_d       = req_q;
      to_cnt_d    = to_cnt_q;
      wr_d        = wr_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      cmd_ready   = '0;
      if ((state_q == ST_REQ || state_q == ST_WAIT_RD) && TIMEOUT != 0)
         to_cnt_d = to_cnt_q + TO_W'(1);
      case (state_q)
         ST_IDLE: begin
            if (gvld_c) begin
               cmd_ready = rst_n ? gnt_c : '0;
               rr_d      = (gidx_c == CH_W'(N_CH - 1)) ? '0 : gidx_c + CH_W'(1);
               ch_d      = gidx_c;
               gsel_d    = gnt_c;
               req_d     = gnt_c;
               wr_d      = wr_sel;
               off_d     = off_sel;
               wdata_d   = wdata_sel;
               to_cnt_d  = '0;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            if (sel_rdy && (wr_q || sel_rvld)) begin
               req_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = wr_q ? '0 : rdata_sel;
               state_d     = ST_RESP;
            end else if (sel_rdy) begin
               req_d    = '0;
               to_cnt_d = '0;
               state_d  = ST_WAIT_RD;
            end else if (to_hit) begin
               req_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = ST_RESP;
            end
         end
         ST_WAIT_RD: begin
            if (sel_rvld || to_hit) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = !sel_rvld;
               rsp_rdata_d = sel_rvld ? rdata_sel : '0;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_q        <= '0;
         ch_q        <= '0;
         gsel_q      <= '0;
         req_q       <= '0;
         to_cnt_q    <= '0;
         wr_q        <= 1'b0;
         off_q       <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         ch_q        <= ch_d;
         gsel_q      <= gsel_d;
         req_q       <= req_d;
         to_cnt_q    <= to_cnt_d;
         wr_q        <= wr_d;
         off_q       <= off_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign lmmi_request = req_q;
   assign lmmi_wr_rdn  = wr_q;
   assign lmmi_offset  = off_q;
   assign lmmi_wdata   = wdata_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_ch       = ch_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_err      = rsp_err_q;

endmodule
